cpu_checkpoint_monitor: RTL and testbench
=========================================

Name: cpu_checkpoint_monitor

Overview:
Synthesizable, parametrised self-check monitor for the CPU.
- Holds a programmable table of checkpoints. Each checkpoint is (cycle, channel, expect, mask).
- After start, counts clocks and compares selected CPU-visible values (regs, led, etc.) against the table.
- Reports pass/fail, error count and first failure, so on-board runs can check themselves.
- Sits beside the cpu instance. Its ch_data is wired to debug_regs/led; its pass/done can drive spare LEDs.

Parameters:
NCH, 9, number of monitored channels (default: regs[0..7] plus led).
DATA_W, 4, width of each channel.
NCHK, 16, checkpoint table depth.
CYC_W, 16, cycle counter width. The counter saturates at 2^CYC_W-1.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
cfg_we  in  1  write a table entry. Ignored while busy.
cfg_idx  in  $clog2(NCHK)  entry index.
cfg_cycle  in  CYC_W  cycle at which to check.
cfg_ch  in  $clog2(NCH)  channel select.
cfg_expect  in  DATA_W  expected value.
cfg_mask  in  DATA_W  bit mask; 1 = compare this bit.
cfg_last  in  1  entry ends the run.
start  in  1  begin run. Ignored while busy.
stop_on_fail  in  1  mode, sampled at start: 1 = end the run on the first mismatch.
ch_data  in  NCH*DATA_W  flattened channels; channel k occupies [k*DATA_W +: DATA_W].
busy  out  1  run in progress.
done  out  1  run finished; held until next start or reset.
pass  out  1  done and err_count==0.
err_count  out  $clog2(NCHK+1)  number of failing entries.
fail_valid  out  1  a failure has been recorded.
fail_idx  out  $clog2(NCHK)  index of the first failing entry.
fail_data  out  DATA_W  channel value seen at the first failure.

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs go to 0.
  - State goes to IDLE; cyc=0; ptr=0.
  - Every table entry is cleared to all-zero (cycle 0, ch 0, expect 0, mask 0, last 0).
  - Reset mid-run aborts the run immediately.
- States: IDLE, RUN, DONE.
  - IDLE/DONE to RUN: start=1 at a clock edge. On that edge: cyc=0, ptr=0, err_count=0, fail_valid/fail_idx/fail_data=0, done=0, pass=0, busy=1, stop_on_fail latched.
  - RUN: exactly one entry, table[ptr], is considered per clock.
    - If table[ptr].cycle > cyc: wait; cyc increments.
    - If table[ptr].cycle == cyc: evaluate it against ch_data sampled at this edge.
    - If table[ptr].cycle < cyc: the entry is stale (out-of-order table). It is counted as a failure with fail_data=0.
    - cyc increments every RUN clock and saturates at 2^CYC_W-1. A run therefore cannot hang: every cycle value is eventually reached.
  - Mismatch rule: ((chan ^ expect) & mask) != 0.
    - cfg_ch >= NCH is always a mismatch, with fail_data=0.
    - mask=0 always passes.
  - On failure: err_count++.
    - If fail_valid==0, latch fail_idx=ptr and fail_data=chan, then set fail_valid=1.
    - Only the first failure is ever latched.
  - RUN to DONE on the same edge as any of:
    - an evaluated (or stale) entry with last=1;
    - an entry at ptr==NCHK-1;
    - a failure with stop_on_fail=1.
  - Otherwise ptr++ after each evaluated or stale entry.
  - In DONE: busy=0, done=1, pass=(err_count==0). Outputs are visible the cycle after the final evaluation edge.
- Programming:
  - cfg_we writes the entry at the edge.
  - A write to the entry currently being evaluated is impossible (writes are ignored while busy).
  - Writes in IDLE/DONE do not change results.
- Simultaneous start and cfg_we in IDLE: the write happens first; the run uses the new entry.

Decomposition:
- Package cpu_mon_pkg holds:
  - state enum mon_state_t {IDLE, RUN, DONE};
  - parameterised-by-localparam chk_entry_t struct (cycle, ch, expect, mask, last);
  - the default parameter constants.
- One sub-module, chk_table:
  - NCHK-entry register file;
  - async-reset clear;
  - one synchronous write port;
  - one combinational read port indexed by ptr.
- Compare, counter and FSM stay in the top module.

Test Plan:
1. Program entries:
   - e0: cycle0, ch8, expect0, mask F.
   - e1: cycle3, ch0, expect2, mask F.
   - e2: cycle5, ch1, expect3, mask F, last.
   - Drive led=0, regs[0]=2 at cyc3, regs[1]=3 at cyc5.
   - Required: done=1 the cycle after cyc5; pass=1; err_count=0; fail_valid=0.
2. Same table, stop_on_fail=0, regs[0]=1 at cyc3:
   - Run reaches e2.
   - Required: err_count=1, fail_idx=1, fail_data=1, pass=0.
3. Same as 2 with stop_on_fail=1:
   - Required: done the cycle after cyc3; e2 not evaluated; err_count=1.
4. Mask and channel checks:
   - e0 cycle2, ch0, expect F, mask 3, last; data 3. Required: pass=1.
   - Repeat with cfg_ch=12 (>= NCH). Required: err_count=1, fail_data=0.
5. Stale entries:
   - e0 cycle4, e1 cycle4 (last).
   - Required: e1 counted stale; err_count=1, fail_idx=1.
6. Reset mid-run:
   - Pull reset low at cyc2. Required: all outputs 0 asynchronously.
   - Release and start with no programming (cleared table). Required: e0 passes (mask 0); e1..e15 stale; done with err_count=15, fail_idx=1, pass=0.

Source files
------------

// File: rtl/cpu_checkpoint_monitor_pkg.sv
// Shared types and default constants for the CPU checkpoint monitor.
package cpu_mon_pkg;

    localparam int NCH_DEF    = 9;
    localparam int DATA_W_DEF = 4;
    localparam int NCHK_DEF   = 16;
    localparam int CYC_W_DEF  = 16;

    // The table entry is sized to these ceilings so one struct serves every
    // parameterisation. Narrower fields are zero-extended on write, and the
    // constant-zero upper bits are removed by synthesis.
    localparam int MAX_CYC_W  = 32;
    localparam int MAX_CH_W   = 8;
    localparam int MAX_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } mon_state_t;

    typedef struct packed {
        logic [MAX_CYC_W-1:0]  cycle;
        logic [MAX_CH_W-1:0]   ch;
        logic [MAX_DATA_W-1:0] exp_val;
        logic [MAX_DATA_W-1:0] mask;
        logic                  last;
    } chk_entry_t;

endpackage

// File: rtl/cpu_checkpoint_monitor_if.sv
// Configuration and status bus of the checkpoint monitor.
interface cpu_checkpoint_monitor_if import cpu_mon_pkg::*; #(
    parameter int NCH    = NCH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int NCHK   = NCHK_DEF,
    parameter int CYC_W  = CYC_W_DEF
);
    logic                       cfg_we;
    logic [$clog2(NCHK)-1:0]    cfg_idx;
    logic [CYC_W-1:0]           cfg_cycle;
    logic [$clog2(NCH)-1:0]     cfg_ch;
    logic [DATA_W-1:0]          cfg_expect;
    logic [DATA_W-1:0]          cfg_mask;
    logic                       cfg_last;
    logic                       start;
    logic                       stop_on_fail;
    logic                       busy;
    logic                       done;
    logic                       pass;
    logic [$clog2(NCHK+1)-1:0]  err_count;
    logic                       fail_valid;
    logic [$clog2(NCHK)-1:0]    fail_idx;
    logic [DATA_W-1:0]          fail_data;

    modport master (
        output cfg_we, cfg_idx, cfg_cycle, cfg_ch, cfg_expect, cfg_mask, cfg_last,
               start, stop_on_fail,
        input  busy, done, pass, err_count, fail_valid, fail_idx, fail_data
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_cycle, cfg_ch, cfg_expect, cfg_mask, cfg_last,
               start, stop_on_fail,
        output busy, done, pass, err_count, fail_valid, fail_idx, fail_data
    );

endinterface

// File: rtl/cpu_checkpoint_monitor_chk_table.sv
// Checkpoint table: NCHK entries, one write port, one combinational read port.
module chk_table import cpu_mon_pkg::*; #(
    parameter int NCHK = NCHK_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [$clog2(NCHK)-1:0] wr_idx,
    input  chk_entry_t              wr_entry,
    input  logic [$clog2(NCHK)-1:0] rd_idx,
    output chk_entry_t              rd_entry
);

    chk_entry_t tbl [NCHK];

    // Entry storage; reset clears every entry to all-zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NCHK; i++) begin
                tbl[i] <= '0;
            end
        end else if (we) begin
            tbl[wr_idx] <= wr_entry;
        end
    end

    assign rd_entry = tbl[rd_idx];

endmodule

// File: rtl/cpu_checkpoint_monitor.sv
// Self-check monitor: walks the checkpoint table against live CPU channels.
module cpu_checkpoint_monitor import cpu_mon_pkg::*; #(
    parameter int NCH    = NCH_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int NCHK   = NCHK_DEF,
    parameter int CYC_W  = CYC_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NCH*DATA_W-1:0]   ch_data,
    cpu_checkpoint_monitor_if.slave mon
);

    localparam int IDX_W = $clog2(NCHK);
    localparam int ERR_W = $clog2(NCHK+1);

    mon_state_t        state_q, state_d;
    logic [CYC_W-1:0]  cyc_q;
    logic [IDX_W-1:0]  ptr_q;
    logic [ERR_W-1:0]  err_q;
    logic              fv_q;
    logic [IDX_W-1:0]  fidx_q;
    logic [DATA_W-1:0] fdata_q;
    logic              sof_q;

    chk_entry_t        wr_entry, cur;
    logic              we_ok;
    logic [DATA_W-1:0] chan;
    logic              ch_ok, hit, stale, mism, fail, consumed, finish;

    // Writes are blocked while a run is in progress.
    assign we_ok = mon.cfg_we && (state_q != RUN);

    // Zero-extend configuration fields into a table entry.
    always_comb begin
        wr_entry         = '0;
        wr_entry.cycle   = MAX_CYC_W'(mon.cfg_cycle);
        wr_entry.ch      = MAX_CH_W'(mon.cfg_ch);
        wr_entry.exp_val = MAX_DATA_W'(mon.cfg_expect);
        wr_entry.mask    = MAX_DATA_W'(mon.cfg_mask);
        wr_entry.last    = mon.cfg_last;
    end

    chk_table #(.NCHK(NCHK)) u_table (
        .clk      (clk),
        .reset    (reset),
        .we       (we_ok),
        .wr_idx   (mon.cfg_idx),
        .wr_entry (wr_entry),
        .rd_idx   (ptr_q),
        .rd_entry (cur)
    );

    // Evaluate table[ptr] against the current cycle and selected channel.
    always_comb begin
        chan = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            if (cur.ch == MAX_CH_W'(k)) begin
                chan = ch_data[k*DATA_W +: DATA_W];
            end
        end
        ch_ok    = cur.ch < MAX_CH_W'(NCH);
        hit      = cur.cycle == MAX_CYC_W'(cyc_q);
        stale    = cur.cycle < MAX_CYC_W'(cyc_q);
        mism     = !ch_ok || (((MAX_DATA_W'(chan) ^ cur.exp_val) & cur.mask) != '0);
        fail     = stale || (hit && mism);
        consumed = hit || stale;
        finish   = consumed && (cur.last || (ptr_q == IDX_W'(NCHK-1)) || (fail && sof_q));
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (mon.start) state_d = RUN;
            RUN:        if (finish)    state_d = DONE;
            default:    state_d = IDLE;
        endcase
    end

    // Run bookkeeping: cycle counter, table pointer and failure record.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q   <= '0;
            ptr_q   <= '0;
            err_q   <= '0;
            fv_q    <= 1'b0;
            fidx_q  <= '0;
            fdata_q <= '0;
            sof_q   <= 1'b0;
        end else if (state_q != RUN) begin
            if (mon.start) begin
                cyc_q   <= '0;
                ptr_q   <= '0;
                err_q   <= '0;
                fv_q    <= 1'b0;
                fidx_q  <= '0;
                fdata_q <= '0;
                sof_q   <= mon.stop_on_fail;
            end
        end else begin
            if (cyc_q != '1) cyc_q <= cyc_q + CYC_W'(1);
            if (fail) begin
                err_q <= err_q + ERR_W'(1);
                if (!fv_q) begin
                    fv_q    <= 1'b1;
                    fidx_q  <= ptr_q;
                    fdata_q <= stale ? '0 : chan;
                end
            end
            if (consumed && !finish) ptr_q <= ptr_q + IDX_W'(1);
        end
    end

    assign mon.busy       = (state_q == RUN);
    assign mon.done       = (state_q == DONE);
    assign mon.pass       = (state_q == DONE) && (err_q == '0);
    assign mon.err_count  = err_q;
    assign mon.fail_valid = fv_q;
    assign mon.fail_idx   = fidx_q;
    assign mon.fail_data  = fdata_q;

endmodule

// File: tb/tb_cpu_checkpoint_monitor.sv
// Self-checking bench for cpu_checkpoint_monitor: directed sequences,
// a compare-vector table and randomized runs against a schedule model.
module tb_cpu_checkpoint_monitor;

    localparam int NCH  = 9;
    localparam int DW   = 4;
    localparam int NCHK = 16;
    localparam int CW   = 16;
    localparam int MAXC = 128;

    typedef struct { int cyc; int ch; int ex; int mask; bit last; } ent_t;
    typedef struct { int ch; int ex; int mask; int val; int err; int fdata; } vec_t;

    logic              clk;
    logic              reset;
    logic [NCH*DW-1:0] ch_data;

    ent_t mt [NCHK];
    int   dat [MAXC][NCH];
    int   n_chk  = 0;
    int   n_fail = 0;

    cpu_checkpoint_monitor_if #(.NCH(NCH), .DATA_W(DW), .NCHK(NCHK), .CYC_W(CW)) mif ();

    cpu_checkpoint_monitor #(.NCH(NCH), .DATA_W(DW), .NCHK(NCHK), .CYC_W(CW)) dut (
        .clk     (clk),
        .reset   (reset),
        .ch_data (ch_data),
        .mon     (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d", nm, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, " busy"},       int'(mif.busy),       0);
        chk({tag, " done"},       int'(mif.done),       0);
        chk({tag, " pass"},       int'(mif.pass),       0);
        chk({tag, " err_count"},  int'(mif.err_count),  0);
        chk({tag, " fail_valid"}, int'(mif.fail_valid), 0);
        chk({tag, " fail_idx"},   int'(mif.fail_idx),   0);
        chk({tag, " fail_data"},  int'(mif.fail_data),  0);
    endtask

    task automatic check_outs(input string tag, input int lat, input int e_lat,
                              input int e_err, input int e_fidx, input int e_fdata);
        chk({tag, " latency"},    lat,                  e_lat);
        chk({tag, " err_count"},  int'(mif.err_count),  e_err);
        chk({tag, " fail_valid"}, int'(mif.fail_valid), (e_err > 0) ? 1 : 0);
        chk({tag, " fail_idx"},   int'(mif.fail_idx),   e_fidx);
        chk({tag, " fail_data"},  int'(mif.fail_data),  e_fdata);
        chk({tag, " pass"},       int'(mif.pass),       (e_err == 0) ? 1 : 0);
    endtask

    task automatic fill_dat(input int v);
        for (int t = 0; t < MAXC; t++)
            for (int k = 0; k < NCH; k++) dat[t][k] = v;
    endtask

    task automatic drive_dat(input int t);
        for (int k = 0; k < NCH; k++) ch_data[k*DW +: DW] = 4'(dat[t][k]);
    endtask

    task automatic set_cfg(input int idx, input ent_t e);
        mif.cfg_idx    = 4'(idx);
        mif.cfg_cycle  = 16'(e.cyc);
        mif.cfg_ch     = 4'(e.ch);
        mif.cfg_expect = 4'(e.ex);
        mif.cfg_mask   = 4'(e.mask);
        mif.cfg_last   = e.last;
    endtask

    task automatic wr(input int idx, input ent_t e);
        @(negedge clk);
        set_cfg(idx, e);
        mif.cfg_we = 1'b1;
        @(negedge clk);
        mif.cfg_we = 1'b0;
        mt[idx] = e;
    endtask

    function automatic ent_t rand_ent(input int base);
        ent_t e;
        e.cyc  = base;
        e.ch   = ($urandom_range(0, 7) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
        e.ex   = int'($urandom_range(0, 15));
        e.mask = int'($urandom_range(0, 15) & $urandom_range(0, 15));
        e.last = ($urandom_range(0, 9) == 0);
        return e;
    endfunction

    // Starts a run (optionally writing an entry on the start edge), feeds
    // dat[cyc] each run cycle, and returns the clocks from start to done.
    task automatic run(input bit sof, input bit swr, input int sidx, input ent_t se,
                       input bit junk, output int lat);
        @(negedge clk);
        mif.start        = 1'b1;
        mif.stop_on_fail = sof;
        if (swr) begin
            set_cfg(sidx, se);
            mif.cfg_we = 1'b1;
            mt[sidx]   = se;
        end
        @(posedge clk);
        @(negedge clk);
        mif.start        = 1'b0;
        mif.cfg_we       = 1'b0;
        mif.stop_on_fail = !sof;
        chk("busy after start", int'(mif.busy), 1);
        chk("done cleared by start", int'(mif.done), 0);
        lat = 0;
        for (int k = 0; k < MAXC - 1; k++) begin
            drive_dat(k);
            if (junk) begin
                set_cfg(int'($urandom_range(0, 15)), rand_ent(int'($urandom_range(0, 40))));
                mif.cfg_we = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            mif.cfg_we = 1'b0;
            if (mif.done) begin
                lat = k + 1;
                break;
            end
        end
        chk("done within budget", int'(mif.done), 1);
        chk("busy low at done", int'(mif.busy), 0);
    endtask

    // Each entry is checked at the later of its programmed cycle and one past
    // the previous entry's check; landing later than programmed means stale.
    function automatic void model(input bit sof, output int lat, output int err,
                                  output int fidx, output int fdata);
        int  tp;
        int  t;
        int  cv;
        bit  stl;
        bit  f;
        bit  fv;
        tp = -1; err = 0; fidx = 0; fdata = 0; lat = 0; fv = 0;
        for (int k = 0; k < NCHK; k++) begin
            stl = (mt[k].cyc <= tp);
            t   = stl ? tp + 1 : mt[k].cyc;
            cv  = (mt[k].ch < NCH) ? dat[t][mt[k].ch] : 0;
            f   = stl || (mt[k].ch >= NCH) || (((cv ^ mt[k].ex) & mt[k].mask) != 0);
            if (f) begin
                err++;
                if (!fv) begin
                    fv    = 1;
                    fidx  = k;
                    fdata = stl ? 0 : cv;
                end
            end
            lat = t + 1;
            if (mt[k].last || (f && sof)) break;
            tp = t;
        end
    endfunction

    vec_t vecs [8];
    ent_t none;

    initial begin
        int lat, e_lat, e_err, e_fidx, e_fdata, prev_err, c;
        bit sof;

        vecs = '{
            '{0,  15, 3,  3,  0, 0},
            '{12, 15, 3,  3,  1, 0},
            '{8,  5,  15, 5,  0, 0},
            '{2,  5,  15, 4,  1, 4},
            '{3,  0,  0,  15, 0, 0},
            '{7,  10, 8,  2,  1, 2},
            '{1,  6,  9,  15, 1, 15},
            '{4,  0,  6,  9,  0, 0}
        };
        none = '{0, 0, 0, 0, 1'b0};

        reset = 1'b0;
        ch_data = '0;
        mif.cfg_we = 1'b0; mif.cfg_idx = '0; mif.cfg_cycle = '0; mif.cfg_ch = '0;
        mif.cfg_expect = '0; mif.cfg_mask = '0; mif.cfg_last = 1'b0;
        mif.start = 1'b0; mif.stop_on_fail = 1'b0;
        for (int k = 0; k < NCHK; k++) mt[k] = none;
        #12;
        check_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // Basic pass; e2 is written on the same edge as start.
        fill_dat(15);
        for (int t = 0; t < MAXC; t++) dat[t][8] = 0;
        dat[3][0] = 2;
        dat[5][1] = 3;
        wr(0, '{0, 8, 0, 15, 1'b0});
        wr(1, '{3, 0, 2, 15, 1'b0});
        run(1'b0, 1'b1, 2, '{5, 1, 3, 15, 1'b1}, 1'b0, lat);
        check_outs("basic", lat, 6, 0, 0, 0);

        // Mismatch at cyc3, run continues to e2.
        dat[3][0] = 1;
        run(1'b0, 1'b0, 0, none, 1'b0, lat);
        check_outs("mismatch", lat, 6, 1, 1, 1);

        // Same mismatch with stop_on_fail: ends right after cyc3.
        run(1'b1, 1'b0, 0, none, 1'b0, lat);
        check_outs("stop_on_fail", lat, 4, 1, 1, 1);

        // Single-entry compare vectors at cycle 2.
        foreach (vecs[i]) begin
            fill_dat((~vecs[i].val) & 15);
            if (vecs[i].ch < NCH) dat[2][vecs[i].ch] = vecs[i].val;
            wr(0, '{2, vecs[i].ch, vecs[i].ex, vecs[i].mask, 1'b1});
            run(1'b0, 1'b0, 0, none, 1'b0, lat);
            check_outs($sformatf("vec%0d", i), lat, 3, vecs[i].err, 0, vecs[i].fdata);
        end

        // Out-of-order table: e1 shares e0's cycle and becomes stale.
        fill_dat(0);
        wr(0, '{4, 0, 0, 0, 1'b0});
        wr(1, '{4, 0, 0, 0, 1'b1});
        run(1'b0, 1'b0, 0, none, 1'b0, lat);
        check_outs("stale", lat, 6, 1, 1, 0);

        // Reset mid-run, then a run over the cleared table.
        @(negedge clk);
        mif.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mif.start = 1'b0;
        drive_dat(0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("busy before mid-run reset", int'(mif.busy), 1);
        #1 reset = 1'b0;
        #1 check_zero("mid-run reset");
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < NCHK; k++) mt[k] = none;
        run(1'b0, 1'b0, 0, none, 1'b0, lat);
        check_outs("cleared table", lat, 16, 15, 1, 0);
        prev_err = 15;

        // Randomized runs with busy-time write attempts.
        for (int it = 0; it < 40; it++) begin
            for (int t = 0; t < MAXC; t++)
                for (int k = 0; k < NCH; k++) dat[t][k] = int'($urandom_range(0, 15));
            c = 0;
            for (int k = 0; k < NCHK; k++) begin
                if ($urandom_range(0, 7) == 0) c = int'($urandom_range(0, 40));
                else c = c + int'($urandom_range(0, 3));
                if (c > 40) c = 40;
                wr(k, rand_ent(c));
            end
            chk("results held through idle writes", int'(mif.err_count), prev_err);
            sof = 1'($urandom_range(0, 1));
            run(sof, 1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                rand_ent(int'($urandom_range(0, 40))), 1'b1, lat);
            model(sof, e_lat, e_err, e_fidx, e_fdata);
            check_outs($sformatf("rand%0d", it), lat, e_lat, e_err, e_fidx, e_fdata);
            prev_err = e_err;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
